// File: rtl/key_sender_if.sv
// Handshake bundle between the key host, the key_sender and the downstream checker.
// Ports: start/key/start_ready (load side), data/data_valid/data_ready (symbol stream),
//        busy/done (status). master = host/checker side, slave = key_sender.
interface key_sender_if;
  logic        start;
  logic [55:0] key;
  logic        start_ready;
  logic [6:0]  data;
  logic        data_valid;
  logic        data_ready;
  logic        busy;
  logic        done;

  modport master (
    output start, key, data_ready,
    input  start_ready, data, data_valid, busy, done
  );

  modport slave (
    input  start, key, data_ready,
    output start_ready, data, data_valid, busy, done
  );
endinterface

// File: rtl/key_sender.sv
// Purpose: streams a 56-bit key to a slot-scrambling checker as eight 7-bit symbols.
// Latency: first symbol valid the cycle after an accepted start; done pulses after the 8th consume.
// Backpressure: data_ready low freezes the symbol, slot index and count; data_valid stays high.
// Ports: clk, rst_n (async active-low); ks (slave modport): start/key/start_ready load a key,
//        data/data_valid/data_ready carry symbols, busy spans start..DONE, done is a 1-cycle pulse.
module key_sender #(
  // Slot-index stride used by the checker; must be odd so all 8 slots are visited.
  parameter int unsigned STEP = 5
) (
  input logic         clk,
  input logic         rst_n,
  key_sender_if.slave ks
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] STEP_W = 3'(STEP % 8);

  state_t      state_q, state_d;
  logic [55:0] key_q, key_d;
  logic [2:0]  slot_idx_q, slot_idx_d;
  logic [2:0]  sym_cnt_q, sym_cnt_d;
  logic        init_q;

  logic [55:0] magic;
  logic [6:0]  slot [8];

  logic        start_ready;
  logic [6:0]  data;
  logic        data_valid;
  logic        done;

  // Undo the checker's bit scramble so that, once it writes the symbols back into its
  // slots, its internal word equals the key.
  always_comb begin
    magic         = '0;
    magic[9:0]    = key_q[55:46];
    magic[41:22]  = key_q[45:26];
    magic[21:10]  = key_q[25:14];
    magic[55:42]  = key_q[13:0];
  end

  // Checker slot layout is not in index order; slot N is the 7-bit field it writes at index N.
  always_comb begin
    slot[0] = magic[55:49];
    slot[5] = magic[48:42];
    slot[6] = magic[41:35];
    slot[2] = magic[34:28];
    slot[4] = magic[27:21];
    slot[3] = magic[20:14];
    slot[7] = magic[13:7];
    slot[1] = magic[6:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      key_q      <= '0;
      slot_idx_q <= '0;
      sym_cnt_q  <= '0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      slot_idx_q <= slot_idx_d;
      sym_cnt_q  <= sym_cnt_d;
      // start_ready is held off until the first edge after reset release.
      init_q     <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    slot_idx_d  = slot_idx_q;
    sym_cnt_d   = sym_cnt_q;
    start_ready = 1'b0;
    data        = '0;
    data_valid  = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        start_ready = init_q;
        if (ks.start && init_q) begin
          key_d      = ks.key;
          slot_idx_d = '0;
          sym_cnt_d  = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        data       = slot[slot_idx_q];
        data_valid = 1'b1;
        if (ks.data_ready) begin
          slot_idx_d = slot_idx_q + STEP_W;
          sym_cnt_d  = sym_cnt_q + 3'd1;
          if (sym_cnt_q == 3'd7) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ks.start_ready = start_ready;
  assign ks.data        = data;
  assign ks.data_valid  = data_valid;
  assign ks.done        = done;
  assign ks.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_key_sender.sv
module tb_key_sender;
  localparam int STEP = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  key_sender_if ks_if ();

  key_sender #(.STEP(STEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ks    (ks_if)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [55:0] got_seq;
  int          got_n;
  int          done_n;
  int          done_lat;
  int          start_cyc;

  typedef struct {
    logic [55:0] key;
    logic [55:0] exp_seq;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: expected symbol stream derived straight from the key/slot rules.
  function automatic logic [55:0] model_seq(input logic [55:0] k);
    logic [55:0] m;
    logic [6:0]  s [8];
    logic [55:0] r;
    m = '0;
    m[9:0]   = k[55:46];
    m[41:22] = k[45:26];
    m[21:10] = k[25:14];
    m[55:42] = k[13:0];
    s[0] = m[55:49]; s[5] = m[48:42]; s[6] = m[41:35]; s[2] = m[34:28];
    s[4] = m[27:21]; s[3] = m[20:14]; s[7] = m[13:7];  s[1] = m[6:0];
    r = '0;
    for (int i = 0; i < 8; i++) r[55-7*i -: 7] = s[3'((i * STEP) % 8)];
    return r;
  endfunction

  // Reference checker: stores symbols at idx (advanced by STEP) and rebuilds its word.
  function automatic logic [55:0] checker_word(input logic [55:0] seq);
    logic [6:0]  s [8];
    logic [55:0] m;
    int          idx;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      s[3'(idx)] = seq[55-7*i -: 7];
      idx = (idx + STEP) % 8;
    end
    m = {s[0], s[5], s[6], s[2], s[4], s[3], s[7], s[1]};
    return {m[9:0], m[41:22], m[21:10], m[55:42]};
  endfunction

  // Called at #1 after a posedge with the DUT idle; returns at #1 after the cycle following done.
  task automatic send_key(input logic [55:0] k, input bit rnd_ready, input int poke_at,
                          input string tag);
    logic [6:0] held;
    bit         stalled;
    int         c;
    got_seq  = '0;
    got_n    = 0;
    done_n   = 0;
    done_lat = 0;
    stalled  = 1'b0;
    held     = '0;
    chk({tag, " start_ready"}, 64'(ks_if.start_ready), 64'd1);
    ks_if.start = 1'b1;
    ks_if.key   = k;
    start_cyc   = cyc;
    @(posedge clk); #1;
    ks_if.start = 1'b0;
    ks_if.key   = ~k;
    chk({tag, " first valid"}, 64'(ks_if.data_valid), 64'd1);
    chk({tag, " busy"}, 64'(ks_if.busy), 64'd1);
    c = 1;
    while (done_n == 0) begin
      if (c > 200) begin
        checks++;
        errors++;
        $display("FAIL %s done timeout: got no done, expected done within 200 cycles", tag);
        break;
      end
      if (poke_at == c) begin
        ks_if.start = 1'b1;
        ks_if.key   = k ^ 56'h5A5A_5A5A_5A5A_5A;
      end else begin
        ks_if.start = 1'b0;
      end
      if (ks_if.data_valid) begin
        if (stalled) chk({tag, " stall hold"}, 64'(ks_if.data), 64'(held));
        ks_if.data_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (ks_if.data_ready) begin
          if (got_n < 8) got_seq[55-7*got_n -: 7] = ks_if.data;
          got_n++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = ks_if.data;
        end
      end
      if (ks_if.done) begin
        done_n++;
        done_lat = c;
        chk({tag, " valid in done"}, 64'(ks_if.data_valid), 64'd0);
      end
      @(posedge clk); #1;
      c++;
    end
    ks_if.start = 1'b0;
    chk({tag, " single done"}, 64'(ks_if.done), 64'd0);
    chk({tag, " idle busy"}, 64'(ks_if.busy), 64'd0);
    chk({tag, " symbols"}, 64'(got_n), 64'd8);
    chk({tag, " seq"}, 64'(got_seq), 64'(model_seq(k)));
    chk({tag, " checker word"}, 64'(checker_word(got_seq)), 64'(k));
    if (!rnd_ready) chk({tag, " done latency"}, 64'(done_lat), 64'd9);
  endtask

  initial begin
    vec_t vecs [5];
    int   prev_start;
    bit   done_seen;

    vecs[0] = '{56'h00000000003FFF, {7'h7F, 7'h7F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00}};
    vecs[1] = '{56'hFFC00000000000, {7'h00, 7'h00, 7'h00, 7'h07, 7'h00, 7'h7F, 7'h00, 7'h00}};
    vecs[2] = '{56'h00000000000000, {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00}};
    vecs[3] = '{56'hFFFFFFFFFFFFFF, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}};
    vecs[4] = '{56'h00000000004000, {7'h00, 7'h00, 7'h00, 7'h08, 7'h00, 7'h00, 7'h00, 7'h00}};

    rst_n            = 1'b0;
    ks_if.start      = 1'b0;
    ks_if.key        = '0;
    ks_if.data_ready = 1'b0;

    // Reset held across two edges, then released between edges.
    #17;
    chk("rst start_ready", 64'(ks_if.start_ready), 64'd0);
    chk("rst data_valid", 64'(ks_if.data_valid), 64'd0);
    chk("rst data", 64'(ks_if.data), 64'd0);
    chk("rst busy", 64'(ks_if.busy), 64'd0);
    chk("rst done", 64'(ks_if.done), 64'd0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first edge start_ready", 64'(ks_if.start_ready), 64'd1);

    // Table vectors, issued back-to-back with data_ready held high.
    prev_start = 0;
    for (int i = 0; i < 5; i++) begin
      send_key(vecs[i].key, 1'b0, 0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table seq", i), 64'(got_seq), 64'(vecs[i].exp_seq));
      if (i > 0) chk($sformatf("vec%0d start spacing", i), 64'(start_cyc - prev_start), 64'd10);
      prev_start = start_cyc;
    end

    // Random stalls on a known key.
    send_key(56'h00000000003FFF, 1'b1, 0, "stall");
    chk("stall table seq", 64'(got_seq), 64'(vecs[0].exp_seq));

    // Start with a different key mid-transmission and during DONE must be ignored.
    send_key(56'h123456789ABCDE, 1'b0, 3, "poke_send");
    send_key(56'h0F0F0F0F0F0F0F, 1'b0, 9, "poke_done");

    // Checker "kittens" word.
    send_key(56'd3008192072309708, 1'b0, 0, "kittens");
    chk("kittens open_safe", 64'(checker_word(got_seq) == 56'd3008192072309708), 64'd1);

    // Reset after the third symbol is consumed.
    ks_if.start = 1'b1;
    ks_if.key   = 56'hDEADBEEFCAFE12;
    @(posedge clk); #1;
    ks_if.start      = 1'b0;
    ks_if.data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre-reset valid", 64'(ks_if.data_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst data_valid", 64'(ks_if.data_valid), 64'd0);
    chk("midrst data", 64'(ks_if.data), 64'd0);
    chk("midrst busy", 64'(ks_if.busy), 64'd0);
    chk("midrst start_ready", 64'(ks_if.start_ready), 64'd0);
    done_seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ks_if.done) done_seen = 1'b1;
    end
    chk("midrst no done", 64'(done_seen), 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    if (ks_if.done) done_seen = 1'b1;
    chk("post-rst no done", 64'(done_seen), 64'd0);
    send_key(56'h13579BDF02468A, 1'b0, 0, "after_rst");

    // Random keys with random backpressure.
    for (int n = 0; n < 1000; n++) begin
      logic [55:0] rk;
      rk = {24'($urandom), 32'($urandom)};
      send_key(rk, 1'b1, 0, $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
